adder_rr_arbiter: RTL and testbench



---
 rtl/adder_rr_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_adder_rr_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_rr_arbiter.sv
// Purpose : shares one external WIDTH-bit adder between NREQ requesters using round-robin arbitration.
// Latency : req sampled in cycle T -> gnt in T+1 -> rsp_valid in T+ADD_LAT+3; one operation in flight.
// Backpr. : requests are only sampled in IDLE; a requester holds req/operands until its gnt pulse.
//
// Ports
//   clk, rst                      : clock, synchronous active-high reset
//   req                           : per-requester request, sampled only while idle
//   req_data_in1 / req_data_in2   : packed operands, channel i at bits [i*WIDTH +: WIDTH]
//   gnt                           : one-hot, one-cycle pulse; that channel's operands were taken
//   rsp_valid / rsp_id / rsp_data : one-cycle result pulse, requester index, sum mod 2^WIDTH
//   busy                          : high while an operation is in progress
//   add_data_in1 / add_data_in2   : registered operands driven to the shared adder
//   add_data_out                  : adder result, valid ADD_LAT cycles after its inputs
module adder_rr_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 4,
    parameter int ADD_LAT = 1,
    localparam int ID_W   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_data_in1,
    input  logic [NREQ*WIDTH-1:0] req_data_in2,
    output logic [NREQ-1:0]       gnt,
    output logic                  rsp_valid,
    output logic [ID_W-1:0]       rsp_id,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  busy,
    output logic [WIDTH-1:0]      add_data_in1,
    output logic [WIDTH-1:0]      add_data_in2,
    input  logic [WIDTH-1:0]      add_data_out
);

    // Wide enough to hold ADD_LAT; a 1-bit counter still exists for ADD_LAT == 0.
    localparam int CNT_W = (ADD_LAT > 0) ? $clog2(ADD_LAT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [ID_W-1:0]   ptr;        // highest-priority requester for the next arbitration
    logic [ID_W-1:0]   cur_id;     // requester owning the in-flight operation
    logic [CNT_W-1:0]  wait_cnt;   // adder pipeline cycles still to wait out

    logic              pick_vld;
    logic [ID_W-1:0]   pick_id;
    logic [ID_W-1:0]   ptr_nxt;
    logic [WIDTH-1:0]  pick_op1;
    logic [WIDTH-1:0]  pick_op2;

    // Round-robin search starting at p. The loop walks from the farthest
    // candidate to the nearest, so the nearest set request overwrites the
    // result last and wins without needing an early exit.
    function automatic logic [ID_W:0] rr_pick(
        input logic [NREQ-1:0] r,
        input logic [ID_W-1:0] p
    );
        logic [ID_W:0] res;
        logic [ID_W:0] cand;
        res = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = {1'b0, p} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NREQ)) begin
                cand = cand - (ID_W+1)'(NREQ);
            end
            if (r[cand[ID_W-1:0]]) begin
                res = {1'b1, cand[ID_W-1:0]};
            end
        end
        return res;
    endfunction

    // Arbitration result and the selected channel's operands.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        pick_op1 = '0;
        pick_op2 = '0;
        ptr_nxt  = ptr;

        {pick_vld, pick_id} = rr_pick(req, ptr);

        for (int i = 0; i < NREQ; i++) begin
            if (ID_W'(i) == pick_id) begin
                pick_op1 = req_data_in1[i*WIDTH +: WIDTH];
                pick_op2 = req_data_in2[i*WIDTH +: WIDTH];
            end
        end

        // Pointer moves just past the winner so it drops to lowest priority.
        if (pick_id == ID_W'(NREQ - 1)) begin
            ptr_nxt = '0;
        end else begin
            ptr_nxt = pick_id + 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and the busy output.
    always_comb begin
        state_nxt = state;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (pick_vld) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_cnt == '0) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath registers. gnt and rsp_valid default low each cycle so they
    // only ever pulse for one clock. rsp_valid is raised on the edge that
    // leaves RESP, which places the pulse in the first cycle back in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt          <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_data     <= '0;
            add_data_in1 <= '0;
            add_data_in2 <= '0;
            ptr          <= '0;
            cur_id       <= '0;
            wait_cnt     <= '0;
        end else begin
            gnt       <= '0;
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick_vld) begin
                        gnt          <= NREQ'(1) << pick_id;
                        add_data_in1 <= pick_op1;
                        add_data_in2 <= pick_op2;
                        cur_id       <= pick_id;
                        ptr          <= ptr_nxt;
                        wait_cnt     <= CNT_W'(ADD_LAT);
                    end
                end
                S_WAIT: begin
                    // On the last wait cycle the adder output reflects the
                    // operands latched at grant time.
                    if (wait_cnt == '0) begin
                        rsp_data <= add_data_out;
                        rsp_id   <= cur_id;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    rsp_valid <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_rr_arbiter.sv
module tb_adder_rr_arbiter;

    localparam int NREQ = 4;
    localparam int LAT  = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    // ADD_LAT = 1 instance with a registered adder
    logic [3:0]  req;
    logic [15:0] op1, op2;
    logic [3:0]  gnt;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [3:0]  rsp_data;
    logic        busy;
    logic [3:0]  add_in1, add_in2, add_out;

    // ADD_LAT = 0 instance with a combinational adder
    logic [3:0]  req0;
    logic [15:0] op1_0, op2_0;
    logic [3:0]  gnt0;
    logic        rsp_valid0;
    logic [1:0]  rsp_id0;
    logic [3:0]  rsp_data0;
    logic        busy0;
    logic [3:0]  add0_in1, add0_in2, add0_out;

    adder_rr_arbiter #(.NREQ(4), .WIDTH(4), .ADD_LAT(1)) dut (
        .clk(clk), .rst(rst), .req(req),
        .req_data_in1(op1), .req_data_in2(op2),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .busy(busy), .add_data_in1(add_in1), .add_data_in2(add_in2),
        .add_data_out(add_out)
    );

    adder_rr_arbiter #(.NREQ(4), .WIDTH(4), .ADD_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0),
        .req_data_in1(op1_0), .req_data_in2(op2_0),
        .gnt(gnt0), .rsp_valid(rsp_valid0), .rsp_id(rsp_id0), .rsp_data(rsp_data0),
        .busy(busy0), .add_data_in1(add0_in1), .add_data_in2(add0_in2),
        .add_data_out(add0_out)
    );

    always @(posedge clk) add_out <= add_in1 + add_in2;
    assign add0_out = add0_in1 + add0_in2;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Transaction-level reference: each accepted request schedules its grant,
    // result capture and response on absolute cycle numbers.
    int m_ptr, m_id, m_gnt_at, m_cap_at, m_rsp_at, m_free_at;
    int m_add1, m_add2, m_pend_sum, m_rsp_id, m_rsp_data;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        int w;
        @(posedge clk);
        if (rst) begin
            m_ptr = 0; m_gnt_at = -1; m_cap_at = -1; m_rsp_at = -1;
            m_free_at = cyc + 1; m_add1 = 0; m_add2 = 0;
            m_rsp_id = 0; m_rsp_data = 0; m_id = 0;
        end else if (cyc >= m_free_at && req != 4'b0) begin
            w = -1;
            for (int k = 0; k < NREQ; k++) begin
                if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
            end
            m_id       = w;
            m_add1     = (int'(op1) >> (4 * w)) & 15;
            m_add2     = (int'(op2) >> (4 * w)) & 15;
            m_pend_sum = (m_add1 + m_add2) % 16;
            m_ptr      = (w + 1) % NREQ;
            m_gnt_at   = cyc + 1;
            m_cap_at   = cyc + LAT + 2;
            m_rsp_at   = cyc + LAT + 3;
            m_free_at  = cyc + LAT + 3;
        end
        cyc++;
        if (cyc == m_cap_at) begin
            m_rsp_id   = m_id;
            m_rsp_data = m_pend_sum;
        end
        @(negedge clk);
        chk("m_gnt", int'(gnt), (cyc == m_gnt_at) ? (1 << m_id) : 0);
        chk("m_rsp_valid", int'(rsp_valid), int'(cyc == m_rsp_at));
        chk("m_busy", int'(busy), int'(cyc >= m_gnt_at && cyc < m_rsp_at));
        chk("m_add_in1", int'(add_in1), m_add1);
        chk("m_add_in2", int'(add_in2), m_add2);
        chk("m_rsp_id", int'(rsp_id), m_rsp_id);
        chk("m_rsp_data", int'(rsp_data), m_rsp_data);
    endtask

    // Wait for rsp_valid; returns cycles waited (bounded).
    task automatic wait_rsp(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!rsp_valid && n < 10);
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [15:0] op1;
        logic [15:0] op2;
        int          gnt;
        int          id;
        int          sum;
    } vec_t;

    vec_t tv[8];

    initial begin
        int n, prev;

        // Applied from ptr = 0 in order; the pointer carries between records.
        tv[0] = '{4'b0001, 16'h000E, 16'h0002, 1, 0, 0};   // E+2 wraps to 0
        tv[1] = '{4'b0101, 16'h0500, 16'h0300, 4, 2, 8};   // ptr 1 -> search 1,2
        tv[2] = '{4'b0101, 16'h0009, 16'h0009, 1, 0, 2};   // ptr 3 -> search 3,0
        tv[3] = '{4'b0101, 16'h0F00, 16'h0F00, 4, 2, 14};  // ptr 1 -> 2
        tv[4] = '{4'b1000, 16'hA000, 16'h7000, 8, 3, 1};   // ptr 3 -> 3
        tv[5] = '{4'b1110, 16'h0030, 16'h0040, 2, 1, 7};   // ptr 0 -> 1
        tv[6] = '{4'b0011, 16'h0001, 16'h0000, 1, 0, 1};   // ptr 2 -> search 2,3,0
        tv[7] = '{4'b1111, 16'h00C0, 16'h0040, 2, 1, 0};   // ptr 1 -> 1

        rst = 1'b1; req = 4'b1111; op1 = '0; op2 = '0;
        req0 = '0; op1_0 = '0; op2_0 = '0;

        // Reset with all requests asserted
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_gnt", int'(gnt), 0);
            chk("rst_rsp_valid", int'(rsp_valid), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_add_in1", int'(add_in1), 0);
            chk("rst_add_in2", int'(add_in2), 0);
            chk("rst_busy0", int'(busy0), 0);
        end

        // Round-robin fairness with req held at 1111
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) op1[i*4 +: 4] = 4'(i);
        op2 = 16'h4444;
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            do begin
                tick();
                n++;
            end while (gnt == 4'b0 && n < 10);
            chk("rr_gnt", int'(gnt), 1 << (k % 4));
            if (k > 0) chk("rr_spacing", cyc - prev, 4);
            prev = cyc;
            chk("rr_add_in1", int'(add_in1), k % 4);
            wait_rsp(n);
            chk("rr_rsp_latency", n, 3);
            chk("rr_rsp_id", int'(rsp_id), k % 4);
            chk("rr_rsp_data", int'(rsp_data), (k % 4) + 4);
        end
        req = 4'b0;

        // Table of single requests from a fresh pointer
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            req = tv[i].req; op1 = tv[i].op1; op2 = tv[i].op2;
            tick();
            chk("tv_gnt", int'(gnt), tv[i].gnt);
            chk("tv_add_in1", int'(add_in1), (int'(tv[i].op1) >> (4 * tv[i].id)) & 15);
            chk("tv_add_in2", int'(add_in2), (int'(tv[i].op2) >> (4 * tv[i].id)) & 15);
            req = 4'b0;
            wait_rsp(n);
            chk("tv_rsp_latency", n, 3);
            chk("tv_rsp_id", int'(rsp_id), tv[i].id);
            chk("tv_rsp_data", int'(rsp_data), tv[i].sum);
        end

        // Reset while waiting on channel 3's result
        req = 4'b1000; op1 = 16'h5000; op2 = 16'h1000;
        tick();
        chk("midrst_gnt", int'(gnt), 8);
        req = 4'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("midrst_no_rsp", int'(rsp_valid), 0);
        end
        req = 4'b1010; op1 = 16'h0060; op2 = 16'h0020;
        tick();
        chk("midrst_ptr_gnt", int'(gnt), 2);
        req = 4'b0;
        wait_rsp(n);
        chk("midrst_rsp_id", int'(rsp_id), 1);
        chk("midrst_rsp_data", int'(rsp_data), 8);

        // Random traffic against the reference
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            req = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom_range(0, 15));
            op1 = 16'($urandom);
            op2 = 16'($urandom);
            tick();
        end
        rst = 1'b0; req = 4'b0;
        for (int i = 0; i < 6; i++) tick();

        // Combinational adder build
        req0 = 4'b0100; op1_0 = 16'h0700; op2_0 = 16'h0900;
        tick();
        chk("lat0_gnt", int'(gnt0), 4);
        chk("lat0_busy", int'(busy0), 1);
        chk("lat0_add_in1", int'(add0_in1), 7);
        req0 = 4'b0;
        tick();
        chk("lat0_rsp_early", int'(rsp_valid0), 0);
        tick();
        chk("lat0_rsp_valid", int'(rsp_valid0), 1);
        chk("lat0_rsp_id", int'(rsp_id0), 2);
        chk("lat0_rsp_data", int'(rsp_data0), 0);
        tick();
        chk("lat0_rsp_pulse", int'(rsp_valid0), 0);
        chk("lat0_idle", int'(busy0), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
